// File: rtl/gcd_sched_pkg.sv
// Shared types and encodings for the round-robin GCD scheduler and its datapath.
package gcd_sched_pkg;

   localparam int unsigned DEF_WIDTH   = 16;
   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned SEL_W       = 2;

   // Operand-mux selects (SEL_A/SEL_B) and bus-mux selects (SEL_SUB/SEL_EXT)
   localparam logic [SEL_W-1:0] SEL_A   = 2'd0;
   localparam logic [SEL_W-1:0] SEL_B   = 2'd1;
   localparam logic [SEL_W-1:0] SEL_SUB = 2'd2;
   localparam logic [SEL_W-1:0] SEL_EXT = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ITER   = 3'd3,
      RESP   = 3'd4
   } gcd_state_t;

endpackage

// File: rtl/gcd_dp_core.sv
// Shared subtractive GCD datapath: A/B registers, operand and bus muxes, subtractor, comparator.
// Register contents are undefined until loaded by the controller.
module gcd_dp_core
   import gcd_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic [SEL_W-1:0] sel1,
   input  logic [SEL_W-1:0] sel2,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [WIDTH-1:0] ext,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             lt,
   output logic             gt,
   output logic             eq,
   output logic             a_zero,
   output logic             b_zero
);

   logic [WIDTH-1:0] opnd1;
   logic [WIDTH-1:0] opnd2;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] bus;

   always_comb begin
      opnd1 = (sel1 == SEL_B) ? b : a;
      opnd2 = (sel2 == SEL_B) ? b : a;
      diff  = opnd1 - opnd2;
      bus   = (sel_in == SEL_EXT) ? ext : diff;
   end

   always_ff @(posedge clk) begin
      if (ld_a) a <= bus;
      if (ld_b) b <= bus;
   end

   assign lt     = (a < b);
   assign gt     = (a > b);
   assign eq     = (a == b);
   assign a_zero = (a == '0);
   assign b_zero = (b == '0);

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin arbiter and Moore controller sequencing one shared GCD datapath
// across NUM_REQ requesters, one job in flight at a time.
module gcd_rr_scheduler
   import gcd_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_gcd,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_iters,
   output logic                     busy
);

   gcd_state_t state, state_nxt;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_found;
   logic [WIDTH-1:0] hold_a, hold_b, iters;
   logic [ID_W-1:0]  id_q;
   logic [WIDTH-1:0] op_a [NUM_REQ];
   logic [WIDTH-1:0] op_b [NUM_REQ];

   logic             ld_a, ld_b;
   logic [SEL_W-1:0] sel1, sel2, sel_in;
   logic [WIDTH-1:0] dp_ext, dp_a, dp_b;
   logic             lt, gt, eq, a_zero, b_zero;
   logic             iter_done;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_a[i] = req_a[i*WIDTH +: WIDTH];
      assign op_b[i] = req_b[i*WIDTH +: WIDTH];
   end

   assign iter_done = a_zero | b_zero | eq;

   // First valid requester at or after rr_ptr, wrapping upward
   always_comb begin
      int unsigned cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_found && req_valid[ID_W'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_found) state_nxt = LOAD_A;
         LOAD_A:  state_nxt = LOAD_B;
         LOAD_B:  state_nxt = ITER;
         ITER:    if (iter_done) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore decode of handshake flags and datapath controls
   always_comb begin
      req_ready = '0;
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      sel1      = SEL_A;
      sel2      = SEL_B;
      sel_in    = SEL_EXT;
      dp_ext    = hold_a;
      unique case (state)
         IDLE:   if (grant_found) req_ready[grant_idx] = 1'b1;
         LOAD_A: ld_a = 1'b1;
         LOAD_B: begin
            dp_ext = hold_b;
            ld_b   = 1'b1;
         end
         ITER: begin
            if (!iter_done && lt) begin
               sel1   = SEL_B;
               sel2   = SEL_A;
               sel_in = SEL_SUB;
               ld_b   = 1'b1;
            end else if (!iter_done && gt) begin
               sel_in = SEL_SUB;
               ld_a   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Arbitration pointer, operand hold, iteration count and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         hold_a    <= '0;
         hold_b    <= '0;
         id_q      <= '0;
         iters     <= '0;
         rsp_gcd   <= '0;
         rsp_id    <= '0;
         rsp_iters <= '0;
      end else begin
         if (state == IDLE && grant_found) begin
            hold_a <= op_a[grant_idx];
            hold_b <= op_b[grant_idx];
            id_q   <= grant_idx;
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         end
         if (state == LOAD_B) iters <= '0;
         else if (state == ITER && !iter_done) iters <= iters + WIDTH'(1);
         if (state == ITER && iter_done) begin
            rsp_gcd   <= (a_zero || b_zero) ? (dp_a | dp_b) : dp_a;
            rsp_id    <= id_q;
            rsp_iters <= iters;
         end
      end
   end

   gcd_dp_core #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .ld_a   (ld_a),
      .ld_b   (ld_b),
      .sel1   (sel1),
      .sel2   (sel2),
      .sel_in (sel_in),
      .ext    (dp_ext),
      .a      (dp_a),
      .b      (dp_b),
      .lt     (lt),
      .gt     (gt),
      .eq     (eq),
      .a_zero (a_zero),
      .b_zero (b_zero)
   );

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed plus randomized bench for gcd_rr_scheduler against a Euclid-based reference.
module tb_gcd_rr_scheduler;

   localparam int unsigned NR = 4;
   localparam int unsigned W  = 16;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*W-1:0]  req_a;
   logic [NR*W-1:0]  req_b;
   logic [NR-1:0]    req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_gcd;
   logic [1:0]       rsp_id;
   logic [W-1:0]     rsp_iters;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   gcd_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_gcd   (rsp_gcd),
      .rsp_id    (rsp_id),
      .rsp_iters (rsp_iters),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Euclid by division; subtraction count is the sum of quotients, minus one on the final step
   function automatic void ref_gcd(input int a, input int b, output int g, output int k);
      int x, y, q, r;
      k = 0;
      if (a == 0 || b == 0) begin
         g = a | b;
      end else begin
         x = (a > b) ? a : b;
         y = (a > b) ? b : a;
         while (y != 0) begin
            q = x / y;
            r = x % y;
            k = k + ((r == 0) ? q - 1 : q);
            x = y;
            y = r;
         end
         g = x;
      end
   endfunction

   task automatic set_req(input int id, input int a, input int b);
      req_a[id*W +: W] = W'(a);
      req_b[id*W +: W] = W'(b);
      req_valid[id]    = 1'b1;
   endtask

   // Expects requester id to be granted next; checks latency, result and response stall
   task automatic serve(input int id, input int stall);
      int g, k, n, cnt;
      logic [W-1:0] a, b;
      a = req_a[id*W +: W];
      b = req_b[id*W +: W];
      ref_gcd(int'(a), int'(b), g, k);
      if (stall > 0) rsp_ready = 1'b0;
      #1;
      n = 0;
      while (req_ready === '0 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      chk($sformatf("grant_id%0d", id), 32'(req_ready), 32'(1) << id);
      @(posedge clk);
      @(negedge clk);
      req_valid[id] = 1'b0;
      cnt = 1;
      while (rsp_valid !== 1'b1 && cnt < 70000) begin
         chk("ready_low_while_busy", 32'(req_ready), 0);
         @(negedge clk);
         cnt++;
      end
      chk($sformatf("latency_id%0d", id), cnt, 4 + k);
      chk($sformatf("gcd_id%0d", id), 32'(rsp_gcd), g);
      chk($sformatf("iters_id%0d", id), 32'(rsp_iters), k);
      chk($sformatf("rsp_id_id%0d", id), 32'(rsp_id), id);
      chk("busy_in_resp", 32'(busy), 1);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid), 1);
         chk("stall_gcd", 32'(rsp_gcd), g);
         chk("stall_iters", 32'(rsp_iters), k);
         chk("stall_ready_low", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rsp_valid_drop", 32'(rsp_valid), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_gcd", 32'(rsp_gcd), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_iters", 32'(rsp_iters), 0);
      rst_n = 1'b1;
      @(negedge clk);

      set_req(0, 48, 18);
      serve(0, 0);
      set_req(2, 0, 7);
      serve(2, 0);
      set_req(2, 0, 0);
      serve(2, 0);

      // rr_ptr is 3: requester 3 wins, requester 0 waits through the stalled response
      set_req(3, 15, 5);
      set_req(0, $urandom_range(1, 200), $urandom_range(1, 200));
      serve(3, 5);
      serve(0, 0);

      set_req(1, 65535, 1);
      serve(1, 0);
      set_req(2, $urandom_range(0, 255), $urandom_range(0, 255));
      serve(2, 0);
      set_req(3, $urandom_range(0, 255), $urandom_range(0, 255));
      serve(3, 0);

      set_req(0, 12, 8);
      set_req(1, 9, 6);
      set_req(2, 7, 7);
      set_req(3, 35, 14);
      serve(0, 0);
      serve(1, 0);
      serve(2, 0);
      serve(3, 0);
      set_req(3, $urandom_range(0, 255), $urandom_range(0, 255));
      set_req(0, $urandom_range(0, 255), $urandom_range(0, 255));
      serve(0, 0);
      serve(3, 0);

      // Reset during ITER drops the job and returns the pointer to 0
      set_req(2, 100, 3);
      #1;
      chk("rst_mid_grant", 32'(req_ready), 32'b0100);
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_mid_req_ready", 32'(req_ready), 0);
      chk("rst_mid_gcd", 32'(rsp_gcd), 0);
      chk("rst_mid_id", 32'(rsp_id), 0);
      chk("rst_mid_iters", 32'(rsp_iters), 0);
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", 32'(rsp_valid), 0);
      end
      set_req(1, 10, 4);
      set_req(3, $urandom_range(0, 255), $urandom_range(0, 255));
      serve(1, 0);
      serve(3, 0);

      for (int j = 0; j < 12; j++) begin
         int id;
         id = int'($urandom_range(0, NR - 1));
         set_req(id, $urandom_range(0, 255), $urandom_range(0, 255));
         serve(id, (j % 4 == 3) ? 2 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gcd_rr_scheduler.md
# gcd_rr_scheduler

Round-robin scheduler that shares one subtractive GCD datapath (A/B registers, operand muxes, subtractor, comparator) between NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake, sequences the load/compare/subtract loop, and returns the result, the requester ID and the subtraction count over a response handshake. The block sits between the request-producing blocks and the shared GCD engine. It replaces ad hoc, delay-based sequencing with a fully synchronous Moore controller.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_gcd  out  WIDTH  GCD result
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served
- rsp_iters  out  WIDTH  number of subtractions performed
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_A, LOAD_B, ITER, RESP.
- **IDLE:** if any req_valid is high, grant the first valid requester at or after rr_ptr, searching upward with wrap. req_ready is combinational from req_valid and rr_ptr, and is asserted only in IDLE. On the handshake:
  - capture the operands into hold_a/hold_b and the index into id_q;
  - set rr_ptr to (grant+1) mod NUM_REQ;
  - go to LOAD_A.
- **LOAD_A:** sel_in = external, ld_a = 1 (A <= hold_a); go to LOAD_B.
- **LOAD_B:** sel_in = external, ld_b = 1 (B <= hold_b); clear iters; go to ITER.
- **ITER** (evaluated on the registered A and B):
  - A==0 or B==0: result <= A|B, go to RESP. This gives gcd(0,x)=x and gcd(0,0)=0, and avoids the non-terminating loop.
  - A==B: result <= A, go to RESP.
  - A<B: B <= B-A (sel1 selects B, sel2 selects A, sel_in = subtractor, ld_b), iters++.
  - A>B: A <= A-B, iters++.
- **RESP:** rsp_valid=1. rsp_gcd, rsp_id and rsp_iters come from registers and stay stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE.
- Width rules:
  - Subtraction is unsigned WIDTH-bit and never underflows, because the smaller value is always the one subtracted.
  - iters is WIDTH bits. The maximum count is 2^WIDTH-2, so it cannot overflow.
- Requesters must hold req_valid and their operands stable until req_ready. A requester that drops valid before being granted is skipped with no side effect.
- One job is in flight at a time. No request is granted during LOAD_A through RESP.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_gcd=0, rsp_id=0, rsp_iters=0, busy=0. All datapath load enables are 0.
- Reset mid-operation: the in-flight job is dropped with no response, and rr_ptr returns to 0.
- Latency, counting the handshake cycle as cycle 0:
  - LOAD_A is cycle 1, LOAD_B is cycle 2, and the first ITER is cycle 3.
  - With k subtractions, rsp_valid first rises in cycle 4+k.
- Throughput: the earliest next grant is the cycle after the rsp_valid & rsp_ready handshake.
- Simultaneous requests: exactly one grant per IDLE cycle. The other requesters keep waiting with valid held.
- Datapath control signals are pure functions of the state and the registered comparator flags, so there are no combinational loops through req_ready.

## Structure
- Package gcd_sched_pkg holds:
  - the state enum (gcd_state_t);
  - default WIDTH and NUM_REQ localparams;
  - the mux select encodings (SEL_A, SEL_B, SEL_SUB, SEL_EXT).
- Sub-module gcd_dp_core: A/B registers with load enables, two operand muxes, the bus mux, the subtractor, and a comparator with lt/gt/eq/a_zero/b_zero outputs plus the A and B values. It has no reset of its own; its contents are don't-care until loaded.
- Top level holds the FSM, the round-robin pointer, the hold registers, the iteration counter and the response registers.

## Test plan
- Requester 0 sends (48,18) with rsp_ready=1 → handshake in cycle 0, rsp_valid in cycle 8, rsp_gcd=6, rsp_iters=4, rsp_id=0.
- Requester 2 sends (0,7), then (0,0) → rsp_gcd=7 then 0, rsp_iters=0, rsp_valid in cycle 4 after each handshake.
- All four requesters valid at once with (12,8), (9,6), (7,7), (35,14) → grant order 0,1,2,3 with gcd 4, 3, 7, 7; rr_ptr wraps back to 0.
- Result (15,5) with rsp_ready held low for 5 cycles → rsp_valid, rsp_gcd=5 and rsp_iters=2 remain stable; req_ready stays 0 throughout; a pending requester is granted only after the handshake.
- Requester 1 sends (65535,1) → rsp_gcd=1, rsp_iters=65534, no counter overflow.
- rst_n driven low for one cycle during ITER → next cycle state=IDLE, all outputs at reset values, no rsp_valid. A following request (10,4) returns 2 normally.
